// File: rtl/ififo_loader_pkg.sv
// ififo_loader_pkg: FSM encoding and default geometry shared by the input-FIFO path and MAC array
package ififo_loader_pkg;
    localparam int def_col = 8;
    localparam int def_bw  = 16;
    localparam int def_aw  = 11;
    typedef logic [1:0] state_t;
    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_read  = 2'd1;
    localparam logic [1:0] st_drain = 2'd2;
    localparam logic [1:0] st_done  = 2'd3;
endpackage

// File: rtl/ififo_loader_skew_lane.sv
// skew_lane: depth-stage delay line plus registered output stage, shifting only on advance
module skew_lane
    import ififo_loader_pkg::*;
#(
    parameter int depth = 0,
    parameter int bw    = def_bw
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_adv,
    input  logic          i_valid,
    input  logic [bw-1:0] i_data,
    output logic          o_valid,
    output logic [bw-1:0] o_data
);
    logic [depth:0] r_v;
    logic [bw-1:0]  r_d [0:depth];
    // data only moves with a valid word so the output holds its last written value
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_v <= '0;
            for (int k = 0; k <= depth; k++) r_d[k] <= '0;
        end else if (i_adv) begin
            r_v[0] <= i_valid;
            if (i_valid) r_d[0] <= i_data;
            for (int k = 1; k <= depth; k++) begin
                r_v[k] <= r_v[k-1];
                if (r_v[k-1]) r_d[k] <= r_d[k-1];
            end
        end
    end
    assign o_valid = r_v[depth];
    assign o_data  = r_d[depth];
endmodule

// File: rtl/ififo_loader.sv
// ififo_loader: streams a tile of SRAM rows into the skewed input-FIFO bank, stalling on FIFO backpressure
module ififo_loader
    import ififo_loader_pkg::*;
#(
    parameter int col = def_col,
    parameter int bw  = def_bw,
    parameter int aw  = def_aw
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [aw-1:0]     i_base_addr,
    input  logic [aw-1:0]     i_num_rows,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sram_cen,
    output logic [aw-1:0]     o_sram_addr,
    input  logic [col*bw-1:0] i_sram_q,
    input  logic              i_ififo_ready,
    output logic [col-1:0]    o_ififo_wr,
    output logic [col*bw-1:0] o_ififo_in
);
    state_t            r_state, w_state_nxt;
    logic [aw-1:0]     r_base, r_num, r_rd_cnt, r_wr_cnt;
    logic              r_rd_pend, r_skid_v;
    logic [col*bw-1:0] r_skid;
    logic              w_read, w_last_rd, w_last_wr, w_in_v;
    logic [col*bw-1:0] w_in_d;
    logic [col-1:0]    w_lane_v;

    assign w_read    = (r_state == st_read) && i_ififo_ready;
    assign w_last_rd = w_read && (r_rd_cnt + aw'(1) == r_num);
    assign w_last_wr = w_lane_v[col-1] && i_ififo_ready && (r_wr_cnt + aw'(1) == r_num);

    always_comb
        w_state_nxt = (r_state == st_idle)  ? (!i_start ? st_idle : (i_num_rows == '0) ? st_drain : st_read) :
                      (r_state == st_read)  ? (w_last_rd ? st_drain : st_read) :
                      (r_state == st_drain) ? ((r_num == '0 || w_last_wr) ? st_done : st_drain) :
                      st_idle;

    // a read issued just before a stall lands in the skid entry, and the skid drains before any new read returns
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= st_idle;
            r_base    <= '0;
            r_num     <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_rd_pend <= 1'b0;
            r_skid_v  <= 1'b0;
            r_skid    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_read;
            if (r_state == st_idle && i_start) begin
                r_base   <= i_base_addr;
                r_num    <= i_num_rows;
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end
            if (w_read) r_rd_cnt <= r_rd_cnt + aw'(1);
            if (w_lane_v[col-1] && i_ififo_ready) r_wr_cnt <= r_wr_cnt + aw'(1);
            if (i_ififo_ready) r_skid_v <= 1'b0;
            else if (r_rd_pend) begin
                r_skid_v <= 1'b1;
                r_skid   <= i_sram_q;
            end
        end
    end

    assign w_in_v = r_skid_v | r_rd_pend;
    assign w_in_d = r_skid_v ? r_skid : i_sram_q;

    for (genvar g = 0; g < col; g++) begin : g_lane
        skew_lane #(.depth(g), .bw(bw)) u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_adv   (i_ififo_ready),
            .i_valid (w_in_v),
            .i_data  (w_in_d[g*bw +: bw]),
            .o_valid (w_lane_v[g]),
            .o_data  (o_ififo_in[g*bw +: bw])
        );
    end

    assign o_ififo_wr  = w_lane_v & {col{i_ififo_ready}};
    assign o_busy      = (r_state == st_read) || (r_state == st_drain);
    assign o_done      = (r_state == st_done);
    assign o_sram_cen  = !w_read;
    assign o_sram_addr = r_base + r_rd_cnt;
endmodule

// File: tb/tb_ififo_loader.sv
// tb_ififo_loader: directed and randomized checks of the skewed FIFO loader against a ready-cycle timing model
module tb_ififo_loader;
    localparam int col = 8;
    localparam int bw  = 16;
    localparam int aw  = 11;
    logic clk = 0, reset = 1, start = 0, ready = 1;
    logic [aw-1:0] base_addr = '0, num_rows = '0, sram_addr;
    logic busy, done, sram_cen;
    logic [col*bw-1:0] sram_q = '0, ififo_in;
    logic [col-1:0] ififo_wr;
    logic a_start = 0, a_busy, a_done, a_cen;
    logic [3:0] a_base = '0, a_num = '0, a_addr;
    logic [1:0] a_wr;
    logic [15:0] a_in, a_q = 16'hA5C3;
    int n_chk = 0, n_pass = 0;
    logic rdy_hist [0:1023];
    int rcyc [0:127];
    logic [aw-1:0] raddr [0:127];
    int rn;
    int wcyc [col][0:127];
    logic [bw-1:0] wdat [col][0:127];
    int wn [col];
    int done_cyc, n_done, n_busy, wr_stalled;

    ififo_loader #(.col(col), .bw(bw), .aw(aw)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr), .i_num_rows(num_rows),
        .o_busy(busy), .o_done(done), .o_sram_cen(sram_cen), .o_sram_addr(sram_addr), .i_sram_q(sram_q),
        .i_ififo_ready(ready), .o_ififo_wr(ififo_wr), .o_ififo_in(ififo_in));

    ififo_loader #(.col(2), .bw(8), .aw(4)) dut_w (
        .i_clk(clk), .i_reset(reset), .i_start(a_start), .i_base_addr(a_base), .i_num_rows(a_num),
        .o_busy(a_busy), .o_done(a_done), .o_sram_cen(a_cen), .o_sram_addr(a_addr), .i_sram_q(a_q),
        .i_ififo_ready(1'b1), .o_ififo_wr(a_wr), .o_ififo_in(a_in));

    always #5 clk = ~clk;

    always @(posedge clk) sram_q <= !sram_cen ? word(sram_addr) : {$urandom(), $urandom(), $urandom(), $urandom()};

    function automatic logic [col*bw-1:0] word(input logic [aw-1:0] a);
        logic [col*bw-1:0] w;
        for (int i = 0; i < col; i++) w[i*bw +: bw] = 16'(a * 97 + i * 4369 + 23100);
        return w;
    endfunction

    function automatic int nth_ready(input int n);
        int cnt = 0;
        for (int t = 1; t < 1024; t++) if (rdy_hist[t]) begin
            cnt++;
            if (cnt == n) return t;
        end
        return -1;
    endfunction

    function automatic int exp_done(input int num);
        int t;
        if (num == 0) return 2;
        t = nth_ready(num + col + 1);
        return (t < 0) ? -2 : t + 1;
    endfunction

    function automatic int read_errors(input logic [aw-1:0] base, input int num);
        int e = (rn != num) ? 1 : 0;
        for (int k = 0; k < num && k < rn; k++)
            if (raddr[k] !== aw'(base + aw'(k)) || rcyc[k] != nth_ready(k + 1)) e++;
        return e;
    endfunction

    function automatic int lane_errors(input logic [aw-1:0] base, input int num);
        int e = 0;
        logic [col*bw-1:0] w;
        for (int i = 0; i < col; i++) begin
            if (wn[i] != num) e++;
            for (int k = 0; k < num && k < wn[i]; k++) begin
                w = word(aw'(base + aw'(k)));
                if (wdat[i][k] !== w[i*bw +: bw] || wcyc[i][k] != nth_ready(k + 3 + i)) e++;
            end
        end
        return e;
    endfunction

    task automatic run_tile(input logic [aw-1:0] base, input logic [aw-1:0] num, input logic [63:0] stall, input bit rnd, input int start2);
        for (int t = 0; t < 1024; t++) rdy_hist[t] = 1'b0;
        rn = 0;
        for (int i = 0; i < col; i++) wn[i] = 0;
        done_cyc = -1; n_done = 0; n_busy = 0; wr_stalled = 0;
        @(posedge clk); #1;
        start = 1; base_addr = base; num_rows = num; ready = 1;
        for (int c = 1; c < 1000; c++) begin
            @(posedge clk); #1;
            start = (c == start2);
            base_addr = aw'($urandom); num_rows = aw'($urandom);
            ready = rnd ? 1'($urandom_range(0, 1)) : !(c < 64 && stall[c]);
            rdy_hist[c] = ready;
            @(negedge clk);
            if (!sram_cen && rn < 128) begin raddr[rn] = sram_addr; rcyc[rn] = c; rn++; end
            for (int i = 0; i < col; i++) if (ififo_wr[i] && wn[i] < 128) begin
                wdat[i][wn[i]] = ififo_in[i*bw +: bw]; wcyc[i][wn[i]] = c; wn[i]++;
            end
            if (ififo_wr != 0 && !ready) wr_stalled++;
            if (busy) n_busy++;
            if (done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        start = 0; ready = 1;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_chk++; if (sram_cen !== 1'b1) $display("FAIL reset_cen: got %b want 1", sram_cen); else n_pass++;
        n_chk++; if (sram_addr !== '0) $display("FAIL reset_addr: got %h want 0", sram_addr); else n_pass++;
        n_chk++; if (ififo_wr !== '0) $display("FAIL reset_wr: got %b want 0", ififo_wr); else n_pass++;
        n_chk++; if (ififo_in !== '0) $display("FAIL reset_in: got %h want 0", ififo_in); else n_pass++;
        n_chk++; if (a_cen !== 1'b1) $display("FAIL reset_wrap_cen: got %b want 1", a_cen); else n_pass++;
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic test_basic();
        run_tile(11'h010, 11'd4, 64'h0, 1'b0, -1);
        n_chk++; if (raddr[0] !== 11'h010 || rcyc[0] != 1) $display("FAIL basic_first_read: got %h@%0d want 010@1", raddr[0], rcyc[0]); else n_pass++;
        n_chk++; if (raddr[3] !== 11'h013 || rcyc[3] != 4) $display("FAIL basic_last_read: got %h@%0d want 013@4", raddr[3], rcyc[3]); else n_pass++;
        n_chk++; if (wcyc[0][0] != 3 || wcyc[0][3] != 6) $display("FAIL basic_lane0_cycles: got %0d..%0d want 3..6", wcyc[0][0], wcyc[0][3]); else n_pass++;
        n_chk++; if (wcyc[7][0] != 10 || wcyc[7][3] != 13) $display("FAIL basic_lane7_cycles: got %0d..%0d want 10..13", wcyc[7][0], wcyc[7][3]); else n_pass++;
        n_chk++; if (done_cyc != 14 || n_done != 1) $display("FAIL basic_done: got cycle %0d count %0d want 14 1", done_cyc, n_done); else n_pass++;
        n_chk++; if (n_busy != 13) $display("FAIL basic_busy_len: got %0d want 13", n_busy); else n_pass++;
        n_chk++; if (read_errors(11'h010, 4) != 0) $display("FAIL basic_reads: got %0d errors want 0", read_errors(11'h010, 4)); else n_pass++;
        n_chk++; if (lane_errors(11'h010, 4) != 0) $display("FAIL basic_lanes: got %0d errors want 0", lane_errors(11'h010, 4)); else n_pass++;
        n_chk++; if (ififo_in !== word(11'h013)) $display("FAIL basic_hold: got %h want %h", ififo_in, word(11'h013)); else n_pass++;
    endtask

    task automatic test_backpressure();
        run_tile(11'h010, 11'd4, 64'h270, 1'b0, -1);
        n_chk++; if (done_cyc != 18) $display("FAIL bp_done: got %0d want 18", done_cyc); else n_pass++;
        n_chk++; if (wr_stalled != 0) $display("FAIL bp_stall_writes: got %0d want 0", wr_stalled); else n_pass++;
        n_chk++; if (read_errors(11'h010, 4) != 0) $display("FAIL bp_reads: got %0d errors want 0", read_errors(11'h010, 4)); else n_pass++;
        n_chk++; if (lane_errors(11'h010, 4) != 0) $display("FAIL bp_lanes: got %0d errors want 0", lane_errors(11'h010, 4)); else n_pass++;
    endtask

    task automatic test_zero_rows();
        int total = 0;
        run_tile(11'h055, 11'd0, 64'h0, 1'b0, -1);
        for (int i = 0; i < col; i++) total += wn[i];
        n_chk++; if (done_cyc != 2 || n_done != 1) $display("FAIL zero_done: got cycle %0d count %0d want 2 1", done_cyc, n_done); else n_pass++;
        n_chk++; if (rn != 0) $display("FAIL zero_reads: got %0d want 0", rn); else n_pass++;
        n_chk++; if (total != 0) $display("FAIL zero_writes: got %0d want 0", total); else n_pass++;
        n_chk++; if (n_busy != 1) $display("FAIL zero_busy_len: got %0d want 1", n_busy); else n_pass++;
    endtask

    task automatic test_addr_wrap();
        logic [3:0] exp_a [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        logic [3:0] ad [4];
        int ac [4];
        int na = 0, got_done = -1;
        @(posedge clk); #1;
        a_start = 1; a_base = 4'd14; a_num = 4'd4;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1 a_start = 0;
            @(negedge clk);
            if (!a_cen && na < 4) begin ad[na] = a_addr; ac[na] = c; na++; end
            if (a_done && got_done < 0) got_done = c;
        end
        n_chk++; if (na != 4) $display("FAIL wrap_count: got %0d want 4", na); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (ad[k] !== exp_a[k] || ac[k] != k + 1) $display("FAIL wrap_addr%0d: got %0d@%0d want %0d@%0d", k, ad[k], ac[k], exp_a[k], k + 1); else n_pass++;
        end
        n_chk++; if (got_done != 8) $display("FAIL wrap_done: got %0d want 8", got_done); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        run_tile(11'h030, 11'd6, 64'h0, 1'b0, 3);
        n_chk++; if (n_done != 1 || done_cyc != 16) $display("FAIL busy_start_done: got cycle %0d count %0d want 16 1", done_cyc, n_done); else n_pass++;
        n_chk++; if (read_errors(11'h030, 6) != 0) $display("FAIL busy_start_reads: got %0d errors want 0", read_errors(11'h030, 6)); else n_pass++;
        n_chk++; if (lane_errors(11'h030, 6) != 0) $display("FAIL busy_start_lanes: got %0d errors want 0", lane_errors(11'h030, 6)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(posedge clk); #1;
        start = 1; base_addr = 11'h020; num_rows = 11'd10; ready = 1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1 start = 0;
            if (c == 6) reset = 1;
        end
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_busy_done: got %b%b want 00", busy, done); else n_pass++;
        n_chk++; if (sram_cen !== 1'b1 || sram_addr !== '0) $display("FAIL rstmid_sram: got %b %h want 1 0", sram_cen, sram_addr); else n_pass++;
        n_chk++; if (ififo_wr !== '0 || ififo_in !== '0) $display("FAIL rstmid_fifo: got %b %h want 0 0", ififo_wr, ififo_in); else n_pass++;
        repeat (30) begin
            @(negedge clk);
            if (done || !sram_cen || ififo_wr != 0) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); else n_pass++;
        run_tile(11'h040, 11'd5, 64'h0, 1'b0, -1);
        n_chk++; if (done_cyc != 15 || n_done != 1) $display("FAIL rstmid_restart_done: got cycle %0d count %0d want 15 1", done_cyc, n_done); else n_pass++;
        n_chk++; if (lane_errors(11'h040, 5) != 0) $display("FAIL rstmid_restart_lanes: got %0d errors want 0", lane_errors(11'h040, 5)); else n_pass++;
    endtask

    task automatic test_random();
        logic [aw-1:0] base;
        int order;
        for (int r = 0; r < 2; r++) begin
            base = aw'($urandom);
            run_tile(base, 11'd64, 64'h0, 1'b1, -1);
            order = 0;
            for (int i = 1; i < col; i++)
                for (int k = 0; k < 64; k++) if (wcyc[i][k] <= wcyc[i-1][k]) order++;
            n_chk++; if (done_cyc != exp_done(64)) $display("FAIL rand%0d_done: got %0d want %0d", r, done_cyc, exp_done(64)); else n_pass++;
            n_chk++; if (wr_stalled != 0) $display("FAIL rand%0d_stall_writes: got %0d want 0", r, wr_stalled); else n_pass++;
            n_chk++; if (wn[0] != 64 || wn[col-1] != 64) $display("FAIL rand%0d_counts: got %0d %0d want 64 64", r, wn[0], wn[col-1]); else n_pass++;
            n_chk++; if (order != 0) $display("FAIL rand%0d_lane_order: got %0d violations want 0", r, order); else n_pass++;
            n_chk++; if (read_errors(base, 64) != 0) $display("FAIL rand%0d_reads: got %0d errors want 0", r, read_errors(base, 64)); else n_pass++;
            n_chk++; if (lane_errors(base, 64) != 0) $display("FAIL rand%0d_lanes: got %0d errors want 0", r, lane_errors(base, 64)); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_rows();
        test_addr_wrap();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ififo_loader.md
# ififo_loader

Streams a tile of activation rows from the activation SRAM into the input-FIFO bank that feeds the MAC array. It is the write side of that FIFO bank. It generates SRAM read addresses and applies the diagonal per-column skew: column i receives each row i cycles after column 0. It drives the per-column write strobes and data lanes, and stalls cleanly whenever the FIFO bank reports it cannot accept data.

## Interface
- col, 8, number of columns / FIFO lanes
- bw, 16, bits per lane word
- aw, 11, SRAM address width (also width of row count)
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse; begins a tile load (ignored while busy)
- base_addr  input  aw  SRAM address of row 0
- num_rows  input  aw  rows to load; 0 is legal
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the final lane write
- sram_cen  output  1  SRAM chip enable, active-low (read when 0)
- sram_addr  output  aw  SRAM read address
- sram_q  input  col*bw  SRAM read data, valid the cycle after sram_cen=0
- ififo_ready  input  1  FIFO bank can accept a write on every lane
- ififo_wr  output  col  per-lane write strobe into the FIFO bank
- ififo_in  output  col*bw  lane data; lane i = bits [(i+1)*bw-1 : i*bw]

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr and num_rows, clears counters, sets busy.
  - Next state is READ, or DRAIN when num_rows=0 (DRAIN is then empty).
- READ:
  - Each cycle with ififo_ready=1 issues one read: sram_cen=0, sram_addr=base_addr+rd_cnt, rd_cnt++.
  - When rd_cnt reaches num_rows, go to DRAIN.
  - With ififo_ready=0: sram_cen=1 and no read is issued.
- Skid register:
  - One entry. It captures sram_q for a read issued in the cycle before a stall.
  - A word in flight is never lost.
  - Words enter the skew pipeline in address order.
- Skew pipeline (advances only on cycles with ififo_ready=1):
  - Lane i holds an i-deep delay line.
  - When a row word enters, lane 0 writes it on that advance; lane i writes its slice i advances later.
  - ififo_wr[i]=1 exactly when lane i presents a valid slice and ififo_ready=1.
  - ififo_in lanes without a write hold their last value.
- DRAIN: continues advancing until every lane of the last row has written. Then go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Address arithmetic is modulo 2^aw; base_addr+rd_cnt wraps silently.
- Each lane receives exactly num_rows writes per tile, in row order.
- start while busy: ignored, with no effect on the active tile.
- Reset mid-tile: immediate return to IDLE, pipeline valids cleared, no done pulse. Already-written FIFO words are the FIFO bank's concern.

## Timing
- Reset values: busy=0, done=0, sram_cen=1, sram_addr=0, ififo_wr=0, ififo_in=0.
- Latency with no stalls; cycle 0 is the cycle start is sampled high:
  - Row r is read in cycle r+1, and sram_q is valid in cycle r+2.
  - ififo_wr[i] for row r is high in cycle r+3+i.
  - The last write is in cycle num_rows+col+1; done is high in cycle num_rows+col+2.
- Each cycle with ififo_ready=0 delays all later events by exactly one cycle. No write occurs in such a cycle.
- ififo_ready is sampled combinationally in the same cycle as the write strobe. ififo_wr and ififo_in are registered, and the qualification with ififo_ready is gated combinationally.
- num_rows=0: done is high in cycle 2, with no SRAM reads and no writes.

## Structure
- Shared package/header holds the FSM state encoding (IDLE, READ, DRAIN, DONE) and the default col/bw/aw constants used by the FIFO bank and the MAC array.
- One sub-module, skew_lane: a parameterized delay line of depth i with valid bit and advance enable, instantiated col times in a generate loop.
- Top-level holds the FSM, the read and write counters, and the skid register.

## Test plan
- Basic tile: col=8, num_rows=4, base_addr=0x10, ififo_ready=1.
  - Reads at 0x10..0x13 in cycles 1..4.
  - ififo_wr[0] in cycles 3..6 and ififo_wr[7] in cycles 10..13.
  - done in cycle 14, with lane data matching the SRAM model.
- Backpressure:
  - Same tile with ififo_ready=0 in cycles 4..6 and 9.
  - No writes during the stalls, no lost or duplicated words.
  - done delayed exactly 4 cycles (cycle 18).
- Zero rows: num_rows=0 -> done in cycle 2, sram_cen stays 1, ififo_wr stays 0.
- Address wrap: aw=4, base_addr=14, num_rows=4 -> reads at addresses 14, 15, 0, 1.
- start while busy, plus reset mid-tile:
  - A second start during a tile is ignored, and exactly one done is produced.
  - reset in cycle 6 -> all outputs return to reset values the next cycle, no done.
  - A new start afterwards completes normally.
- Randomized ififo_ready at 50% over num_rows=64:
  - Scoreboard verifies per-lane order and count (64 each).
  - Lane i's k-th write never precedes lane i-1's k-th write.
